// File: rtl/key_debounce_repeat.sv
// Eight-key synchroniser, tick-based debouncer and press/release/repeat pulser.
// Auto-repeat logic is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_repeat #(
  parameter int NKEY         = 8,
  parameter int TICK_DIV     = 1000,
  parameter int DEB_TICKS    = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter bit KEY_POL      = 1'b1
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic [NKEY-1:0] KEY_RAW,
  output logic [NKEY-1:0] KEY_LEVEL,
  output logic [NKEY-1:0] KEY_PRESS,
  output logic [NKEY-1:0] KEY_RELEASE,
  output logic [NKEY-1:0] KEY_REPEAT,
  output logic            TICK
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEB_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [NKEY-1:0] POL_MASK = KEY_POL ? '0 : '1;

  logic [NKEY-1:0] sync1;
  logic [NKEY-1:0] sync2;
  logic [TW-1:0]   tick_cnt;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= KEY_RAW ^ POL_MASK;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign TICK = (tick_cnt == TICK_LAST);

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DELAY,
    REPEATING
  } rep_state_t;
`endif

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    logic [DW-1:0] deb_cnt;
    logic          level;
    logic          press;
    logic          rel;
    logic          differ;
    logic          accept;

    assign differ = (sync2[i] != level);
    // accept marks the tick on which the new level is taken
    assign accept = TICK && differ && (deb_cnt == DEB_LAST);

    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        deb_cnt <= '0;
        level   <= 1'b0;
        press   <= 1'b0;
        rel     <= 1'b0;
      end else begin
        press <= accept && !level;
        rel   <= accept && level;
        if (TICK) begin
          if (!differ) begin
            deb_cnt <= '0;
          end else if (accept) begin
            deb_cnt <= '0;
            level   <= ~level;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
      end
    end

    assign KEY_LEVEL[i]   = level;
    assign KEY_PRESS[i]   = press;
    assign KEY_RELEASE[i] = rel;

`ifdef KEY_AUTOREPEAT_EN
    rep_state_t    state;
    logic [RW-1:0] rep_cnt;
    logic          rep;

    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        state   <= IDLE;
        rep_cnt <= '0;
        rep     <= 1'b0;
      end else begin
        rep <= 1'b0;
        if (TICK) begin
          case (state)
            IDLE: begin
              if (accept && !level) begin
                state   <= WAIT_DELAY;
                rep_cnt <= '0;
              end
            end
            WAIT_DELAY: begin
              if (accept) begin
                state <= IDLE;
              end else if (rep_cnt == DELAY_LAST) begin
                state   <= REPEATING;
                rep_cnt <= '0;
                rep     <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
            end
            REPEATING: begin
              if (accept) begin
                state <= IDLE;
              end else if (rep_cnt == RATE_LAST) begin
                rep_cnt <= '0;
                rep     <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end

    assign KEY_REPEAT[i] = rep;
`else
    assign KEY_REPEAT[i] = 1'b0;
`endif
  end

endmodule
